// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants for the register-file write-back arbiter slice.
//   NREQ_DEF  : default number of write-back requesters
//   AW_DEF    : default register index width
//   DW_DEF    : default data width
//   PTR_W_DEF : round-robin pointer width for the default NREQ
//   CNT_W     : conflict counter width
package regfile_wb_arbiter_pkg;

   localparam int NREQ_DEF  = 4;
   localparam int AW_DEF    = 5;
   localparam int DW_DEF    = 32;
   localparam int PTR_W_DEF = $clog2(NREQ_DEF);
   localparam int CNT_W     = 16;

   // Pointer width for an arbitrary requester count; never zero so a
   // single-requester build still has a legal vector.
   function automatic int ptr_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Write-back request bus between requesters and the arbiter.
//   req_valid : per-requester request
//   req_reg   : per-requester destination register (packed, AW each)
//   req_data  : per-requester write data (packed, DW each)
//   req_ready : combinational per-requester acknowledge from the arbiter
// Modports: master = requester side, slave = arbiter side.
interface regfile_wb_arbiter_if
   import regfile_wb_arbiter_pkg::*;
#(
   parameter int NREQ = NREQ_DEF,
   parameter int AW   = AW_DEF,
   parameter int DW   = DW_DEF
);
   logic [NREQ-1:0]    req_valid;
   logic [NREQ*AW-1:0] req_reg;
   logic [NREQ*DW-1:0] req_data;
   logic [NREQ-1:0]    req_ready;

   modport master (output req_valid, req_reg, req_data, input req_ready);
   modport slave  (input req_valid, req_reg, req_data, output req_ready);
endinterface

// File: rtl/regfile_wb_arbiter_rr_pick.sv
// Masked find-first-set with wrap: returns the first set bit of req at or
// after ptr, scanning upward modulo NREQ.
//   req   : candidate mask
//   ptr   : starting index
//   found : any candidate present
//   idx   : index of the selected candidate (0 when none)
module regfile_wb_arbiter_rr_pick
   import regfile_wb_arbiter_pkg::*;
#(
   parameter int NREQ = NREQ_DEF,
   parameter int PW   = ptr_width(NREQ)
)(
   input  logic [NREQ-1:0] req,
   input  logic [PW-1:0]   ptr,
   output logic            found,
   output logic [PW-1:0]   idx
);
   always_comb begin
      int unsigned j;
      found = 1'b0;
      idx   = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         j = (32'(ptr) + i) % NREQ;
         if (!found && req[j]) begin
            found = 1'b1;
            idx   = PW'(j);
         end
      end
   end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Dual-port register-file write-back arbiter.
//   clk, rst        : clock, asynchronous active-low reset
//   wb_hold         : suppress all grants and acknowledges
//   req             : request bus (slave side)
//   we1/we2         : registered write enables, ports 1 and 2
//   writeRegister1/2: registered destination indices
//   writeData1/2    : registered write data
//   conflict_cnt    : saturating count of same-register conflict cycles
// Up to two requests with distinct nonzero destinations are granted per
// cycle in round-robin order; r0 writes are acknowledged and dropped.
module regfile_wb_arbiter
   import regfile_wb_arbiter_pkg::*;
#(
   parameter int NREQ = NREQ_DEF,
   parameter int AW   = AW_DEF,
   parameter int DW   = DW_DEF
)(
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    wb_hold,
   regfile_wb_arbiter_if.slave     req,
   output logic                    we1,
   output logic                    we2,
   output logic [AW-1:0]           writeRegister1,
   output logic [AW-1:0]           writeRegister2,
   output logic [DW-1:0]           writeData1,
   output logic [DW-1:0]           writeData2,
   output logic [CNT_W-1:0]        conflict_cnt
);
   localparam int PW = ptr_width(NREQ);

   logic [PW-1:0]   rr_ptr, start2, idx1, idx2;
   logic            g1, g2;
   logic [NREQ-1:0] elig, conf, mask2, zero_dst, ready;
   logic [AW-1:0]   reg1, reg2;
   logic [DW-1:0]   data1, data2;

   always_comb begin
      elig     = '0;
      zero_dst = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         zero_dst[i] = (req.req_reg[i*AW +: AW] == '0);
         elig[i]     = req.req_valid[i] && !zero_dst[i] && !wb_hold;
      end
   end

   regfile_wb_arbiter_rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick1 (
      .req   (elig),
      .ptr   (rr_ptr),
      .found (g1),
      .idx   (idx1)
   );

   always_comb begin
      reg1   = req.req_reg[32'(idx1)*AW +: AW];
      data1  = req.req_data[32'(idx1)*DW +: DW];
      start2 = (32'(idx1) == NREQ - 1) ? '0 : idx1 + PW'(1);
      conf   = '0;
      mask2  = '0;
      // Second pick sees everything eligible except the first grant and
      // anything targeting the same register as it.
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (g1 && elig[i] && (i != 32'(idx1))) begin
            if (req.req_reg[i*AW +: AW] == reg1) conf[i]  = 1'b1;
            else                                 mask2[i] = 1'b1;
         end
      end
   end

   regfile_wb_arbiter_rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick2 (
      .req   (mask2),
      .ptr   (start2),
      .found (g2),
      .idx   (idx2)
   );

   always_comb begin
      reg2  = req.req_reg[32'(idx2)*AW +: AW];
      data2 = req.req_data[32'(idx2)*DW +: DW];
      ready = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         ready[i] = !wb_hold && req.req_valid[i] &&
                    (zero_dst[i] || (g1 && i == 32'(idx1)) || (g2 && i == 32'(idx2)));
      end
   end

   assign req.req_ready = ready;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         we1            <= 1'b0;
         we2            <= 1'b0;
         writeRegister1 <= '0;
         writeRegister2 <= '0;
         writeData1     <= '0;
         writeData2     <= '0;
         rr_ptr         <= '0;
         conflict_cnt   <= '0;
      end else begin
         we1 <= g1;
         we2 <= g2;
         if (g1) begin
            writeRegister1 <= reg1;
            writeData1     <= data1;
         end
         if (g2) begin
            writeRegister2 <= reg2;
            writeData2     <= data2;
         end
         if (g2)      rr_ptr <= (32'(idx2) == NREQ - 1) ? '0 : idx2 + PW'(1);
         else if (g1) rr_ptr <= start2;
         if ((|conf) && (conflict_cnt != '1)) conflict_cnt <= conflict_cnt + 1'b1;
      end
   end
endmodule
